// File: rtl/logic_capture_engine.sv
// Circular-buffer capture core: pre-trigger prefill, pattern/edge trigger, post-trigger fill into sample RAM.
// Latency: one cycle from sample_valid to mem_we; no backpressure, so every valid sample in a capture state is written.
// Optional edge trigger compiled in with LOGCAP_EDGE_TRIG_EN.
module logic_capture_engine #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_WIDTH   = 12,
    parameter int CHAN_BITS    = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid,
    input  logic                    start,
    input  logic                    abort,
    input  logic [SAMPLE_WIDTH-1:0] cfg_active,
    input  logic [SAMPLE_WIDTH-1:0] cfg_pattern,
    input  logic [SAMPLE_WIDTH-1:0] cfg_care,
    input  logic                    cfg_pattern_en,
    input  logic [CHAN_BITS-1:0]    cfg_edge_chan,
    input  logic                    cfg_edge_rising,
    input  logic                    cfg_edge_en,
    input  logic [ADDR_WIDTH-1:0]   cfg_pre_count,
    input  logic [ADDR_WIDTH:0]     cfg_post_count,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [SAMPLE_WIDTH:0]   mem_wdata,
    output logic [ADDR_WIDTH-1:0]   trigger_addr,
    output logic [ADDR_WIDTH-1:0]   start_addr,
    output logic [7:0]              status
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   wptr;
    logic [ADDR_WIDTH-1:0]   pre_cnt;
    logic [ADDR_WIDTH:0]     post_cnt;
    logic [SAMPLE_WIDTH-1:0] active_l;
    logic [SAMPLE_WIDTH-1:0] pattern_l;
    logic [SAMPLE_WIDTH-1:0] care_l;
    logic                    pattern_en_l;
    logic [ADDR_WIDTH-1:0]   pre_l;
    logic [ADDR_WIDTH:0]     post_l;

    logic [ADDR_WIDTH:0]     post_eff;
    logic [ADDR_WIDTH+1:0]   post_sum;
    logic [ADDR_WIDTH:0]     post_clamped;
    logic                    pattern_hit;
    logic                    edge_hit;
    logic                    edge_en_eff;
    logic                    trig_hit;

    // A zero post length still stores the trigger sample; the post window is
    // shrunk so the oldest pre-trigger sample survives the whole capture.
    always_comb begin
        post_eff     = (cfg_post_count == '0) ? (ADDR_WIDTH+1)'(1) : cfg_post_count;
        post_sum     = (ADDR_WIDTH+2)'(cfg_pre_count) + (ADDR_WIDTH+2)'(post_eff);
        post_clamped = post_eff;
        if (post_sum > (ADDR_WIDTH+2)'(DEPTH))
            post_clamped = (ADDR_WIDTH+1)'(DEPTH) - (ADDR_WIDTH+1)'(cfg_pre_count);
    end

    assign pattern_hit = (((sample_in ^ pattern_l) & care_l & active_l) == '0);

`ifdef LOGCAP_EDGE_TRIG_EN
    logic [CHAN_BITS-1:0]    edge_chan_l;
    logic                    edge_rising_l;
    logic                    edge_en_l;
    logic [SAMPLE_WIDTH-1:0] prev_sample;
    logic                    prev_vld;

    assign edge_en_eff = edge_en_l;
    assign edge_hit    = prev_vld
                       && (sample_in[edge_chan_l] != prev_sample[edge_chan_l])
                       && (sample_in[edge_chan_l] == edge_rising_l);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_chan_l   <= '0;
            edge_rising_l <= 1'b0;
            edge_en_l     <= 1'b0;
            prev_sample   <= '0;
            prev_vld      <= 1'b0;
        end else if ((state == S_IDLE || state == S_DONE) && start && !abort) begin
            edge_chan_l   <= cfg_edge_chan;
            edge_rising_l <= cfg_edge_rising;
            edge_en_l     <= cfg_edge_en;
            prev_vld      <= 1'b0;
        end else if ((state == S_PREFILL || state == S_ARMED || state == S_POST)
                     && !abort && sample_valid) begin
            prev_sample   <= sample_in;
            prev_vld      <= 1'b1;
        end
    end
`else
    logic unused_edge_cfg;

    assign unused_edge_cfg = ^{cfg_edge_chan, cfg_edge_rising, cfg_edge_en};
    assign edge_en_eff     = 1'b0;
    assign edge_hit        = 1'b0;
`endif

    always_comb begin
        trig_hit = 1'b1;
        if (pattern_en_l && edge_en_eff)
            trig_hit = pattern_hit && edge_hit;
        else if (pattern_en_l)
            trig_hit = pattern_hit;
        else if (edge_en_eff)
            trig_hit = edge_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            wptr         <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            active_l     <= '0;
            pattern_l    <= '0;
            care_l       <= '0;
            pattern_en_l <= 1'b0;
            pre_l        <= '0;
            post_l       <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            trigger_addr <= '0;
            start_addr   <= '0;
            status       <= 8'h01;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        active_l     <= cfg_active;
                        pattern_l    <= cfg_pattern;
                        care_l       <= cfg_care;
                        pattern_en_l <= cfg_pattern_en;
                        pre_l        <= cfg_pre_count;
                        post_l       <= post_clamped;
                        wptr         <= '0;
                        pre_cnt      <= '0;
                        post_cnt     <= '0;
                        status       <= 8'h02;
                        state        <= (cfg_pre_count == '0) ? S_ARMED : S_PREFILL;
                    end
                end
                default: begin
                    if (abort) begin
                        state  <= S_IDLE;
                        status <= 8'h11;
                    end else if (sample_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wptr;
                        mem_wdata <= {1'b0, sample_in & active_l};
                        wptr      <= wptr + ADDR_WIDTH'(1);
                        if (state == S_PREFILL) begin
                            pre_cnt <= pre_cnt + ADDR_WIDTH'(1);
                            if (pre_cnt + ADDR_WIDTH'(1) == pre_l)
                                state <= S_ARMED;
                        end else if (state == S_ARMED) begin
                            if (trig_hit) begin
                                mem_wdata    <= {1'b1, sample_in & active_l};
                                trigger_addr <= wptr;
                                start_addr   <= wptr - pre_l;
                                post_cnt     <= (ADDR_WIDTH+1)'(1);
                                if (post_l == (ADDR_WIDTH+1)'(1)) begin
                                    state  <= S_DONE;
                                    status <= 8'h08;
                                end else begin
                                    state  <= S_POST;
                                    status <= 8'h04;
                                end
                            end
                        end else begin
                            post_cnt <= post_cnt + (ADDR_WIDTH+1)'(1);
                            if (post_cnt + (ADDR_WIDTH+1)'(1) == post_l) begin
                                state  <= S_DONE;
                                status <= 8'h08;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
